// File: rtl/gold_code_gen.sv
// rtl/gold_code_gen.sv - parametrised Gold-code PRN generator with chip pacing, epoch and code-phase slew
// Optional GOLD_ELP_EN adds early/late chip outputs for the DLL.
module gold_code_gen #(
    parameter int                LFSR_W   = 10,
    parameter int                CODE_LEN = 1023,
    parameter logic [LFSR_W-1:0] G1_POLY  = 10'h204,
    parameter logic [LFSR_W-1:0] G2_POLY  = 10'h3A6,
    parameter int                TAP_W    = 4,
    parameter int                CNT_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] g1_init,
    input  logic [LFSR_W-1:0] g2_init,
    input  logic [TAP_W-1:0]  T0,
    input  logic [TAP_W-1:0]  T1,
    input  logic              chip_en,
    input  logic              reload,
    input  logic              slew_req,
    input  logic [CNT_W-1:0]  slew_chips,
    output logic              chip,
    output logic [CNT_W-1:0]  chip_cnt,
    output logic              epoch,
    output logic              slew_busy
`ifdef GOLD_ELP_EN
    ,
    output logic              chip_early,
    output logic              chip_late
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_LEN - 1);

    typedef enum logic {IDLE, SLEW} state_t;

    state_t            state;
    logic [LFSR_W-1:0] g1;
    logic [LFSR_W-1:0] g2;
    logic [CNT_W-1:0]  remaining;
    logic              at_last;
    logic              advance;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                     input logic [LFSR_W-1:0] poly);
        return {s[LFSR_W-2:0], ^(s & poly)};
    endfunction

    // Selectors are 1-based; anything outside 1..LFSR_W contributes 0.
    function automatic logic stage_tap(input logic [LFSR_W-1:0] s, input logic [TAP_W-1:0] t);
        logic r;
        r = 1'b0;
        for (int i = 0; i < LFSR_W; i++) begin
            if (int'(t) == i + 1) r = s[i];
        end
        return r;
    endfunction

    function automatic logic gold_out(input logic [LFSR_W-1:0] a, input logic [LFSR_W-1:0] b,
                                      input logic [TAP_W-1:0] t0, input logic [TAP_W-1:0] t1);
        return a[LFSR_W-1] ^ stage_tap(b, t0) ^ stage_tap(b, t1);
    endfunction

    assign at_last = (chip_cnt == LAST);
    assign advance = (state == SLEW) || chip_en;
    assign chip    = gold_out(g1, g2, T0, T1);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            g1        <= g1_init;
            g2        <= g2_init;
            chip_cnt  <= '0;
            epoch     <= 1'b0;
            slew_busy <= 1'b0;
            remaining <= '0;
            state     <= IDLE;
        end else begin
            epoch <= 1'b0;
            if (advance) begin
                if (at_last) begin
                    g1       <= g1_init;
                    g2       <= g2_init;
                    chip_cnt <= '0;
                    epoch    <= 1'b1;
                end else begin
                    g1       <= lfsr_step(g1, G1_POLY);
                    g2       <= lfsr_step(g2, G2_POLY);
                    chip_cnt <= chip_cnt + CNT_W'(1);
                end
            end
            // A chip_en during slew is absorbed by the slew advance, so only idle clocks count down.
            case (state)
                IDLE: begin
                    if (slew_req && (slew_chips != '0)) begin
                        state     <= SLEW;
                        remaining <= slew_chips;
                        slew_busy <= 1'b1;
                    end
                end
                SLEW: begin
                    if (!chip_en) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state     <= IDLE;
                            slew_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef GOLD_ELP_EN
    assign chip_early = at_last ? gold_out(g1_init, g2_init, T0, T1)
                                : gold_out(lfsr_step(g1, G1_POLY), lfsr_step(g2, G2_POLY), T0, T1);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            chip_late <= 1'b0;
        end else if (advance) begin
            chip_late <= chip;
        end
    end
`endif

endmodule

// File: tb/tb_gold_code_gen.sv
// tb/tb_gold_code_gen.sv - self-checking bench for gold_code_gen
// Vector table of GPS PRNs, hand sequences for epoch/slew/reset corners, random run against a phase model.
module tb_gold_code_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] g1_init, g2_init;
    logic [3:0] t0, t1;
    logic       chip_en, reload, slew_req;
    logic [9:0] slew_chips;
    logic       chip, epoch, slew_busy;
    logic [9:0] chip_cnt;
    logic       chip_b, epoch_b, busy_b;
    logic [9:0] cnt_b;
`ifdef GOLD_ELP_EN
    logic       chip_early, chip_late, early_b, late_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gold_code_gen dut (
        .clk(clk), .rst(rst), .g1_init(g1_init), .g2_init(g2_init), .T0(t0), .T1(t1),
        .chip_en(chip_en), .reload(reload), .slew_req(slew_req), .slew_chips(slew_chips),
        .chip(chip), .chip_cnt(chip_cnt), .epoch(epoch), .slew_busy(slew_busy)
`ifdef GOLD_ELP_EN
        , .chip_early(chip_early), .chip_late(chip_late)
`endif
    );

    gold_code_gen #(.CODE_LEN(511)) dut511 (
        .clk(clk), .rst(rst), .g1_init(g1_init), .g2_init(g2_init), .T0(t0), .T1(t1),
        .chip_en(chip_en), .reload(reload), .slew_req(slew_req), .slew_chips(slew_chips),
        .chip(chip_b), .chip_cnt(cnt_b), .epoch(epoch_b), .slew_busy(busy_b)
`ifdef GOLD_ELP_EN
        , .chip_early(early_b), .chip_late(late_b)
`endif
    );

    typedef struct {
        logic [3:0] t0;
        logic [3:0] t1;
        logic [9:0] chips;
    } prn_vec_t;

    prn_vec_t vecs[8];

    // Reference code tables: LFSR state at each chip index of one period.
    logic [9:0] g1_tab[1023];
    logic [9:0] g2_tab[1023];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ref_step(input logic [9:0] s, input logic [9:0] poly);
        logic [9:0] n;
        logic fb;
        fb = 1'b0;
        for (int k = 1; k <= 10; k++) if (poly[k-1]) fb = fb ^ s[k-1];
        n[0] = fb;
        for (int k = 2; k <= 10; k++) n[k-1] = s[k-2];
        return n;
    endfunction

    task automatic build_tables(input logic [9:0] a, input logic [9:0] b);
        g1_tab[0] = a;
        g2_tab[0] = b;
        for (int p = 1; p < 1023; p++) begin
            g1_tab[p] = ref_step(g1_tab[p-1], 10'h204);
            g2_tab[p] = ref_step(g2_tab[p-1], 10'h3A6);
        end
    endtask

    function automatic logic ref_tap(input logic [9:0] s, input logic [3:0] t);
        if (t < 4'd1 || t > 4'd10) return 1'b0;
        return s[t-1];
    endfunction

    function automatic logic exp_chip(input int p);
        return g1_tab[p][9] ^ ref_tap(g2_tab[p], t0) ^ ref_tap(g2_tab[p], t1);
    endfunction

    initial begin
        logic [9:0] got, first10;
        int adv, ep_count, first_ep, second_ep, busy_clks, cnt_bad, ep_at;
        int ph, rem, act, exp;
        logic busy_m, ep_m, late_m;

        vecs[0] = '{4'd2,  4'd6,  10'b1100100000};
        vecs[1] = '{4'd3,  4'd7,  10'b1110010000};
        vecs[2] = '{4'd4,  4'd8,  10'b1111001000};
        vecs[3] = '{4'd5,  4'd9,  10'b1111100100};
        vecs[4] = '{4'd1,  4'd9,  10'b1001011011};
        vecs[5] = '{4'd2,  4'd10, 10'b1100101101};
        vecs[6] = '{4'd5,  4'd5,  10'b1111111111};
        vecs[7] = '{4'd15, 4'd0,  10'b1111111111};

        rst = 1'b1; reload = 1'b0; chip_en = 1'b0; slew_req = 1'b0; slew_chips = '0;
        g1_init = 10'h3FF; g2_init = 10'h3FF; t0 = 4'd2; t1 = 4'd6;
        tick;
        check("reset_cnt", chip_cnt, 0);
        check("reset_epoch", epoch, 0);
        check("reset_busy", slew_busy, 0);
        check("reset_chip", chip, 1);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            t0 = vecs[r].t0; t1 = vecs[r].t1;
            rst = 1'b1; tick; rst = 1'b0;
            chip_en = 1'b1; cnt_bad = 0;
            for (int i = 0; i < 10; i++) begin
                got[9-i] = chip;
                if (chip_cnt != 10'(i)) cnt_bad++;
                tick;
            end
            chip_en = 1'b0;
            check($sformatf("prn_row%0d_chips", r), got, vecs[r].chips);
            check($sformatf("prn_row%0d_cnt_errs", r), cnt_bad, 0);
        end

        // Epoch timing with chip_en every 4th clock.
        t0 = 4'd2; t1 = 4'd6;
        rst = 1'b1; tick; rst = 1'b0;
        adv = 0; ep_count = 0; first_ep = -1; second_ep = -1; got = '0;
        for (int cyc = 0; cyc < 9000 && second_ep < 0; cyc++) begin
            chip_en = (cyc % 4 == 0);
            tick;
            if (chip_en) adv++;
            if (epoch) begin
                ep_count++;
                if (first_ep < 0) begin
                    first_ep = cyc;
                    check("epoch_after_adv", adv, 1023);
                    check("epoch_cnt_zero", chip_cnt, 0);
                end else begin
                    second_ep = cyc;
                end
            end
            if (chip_en && adv >= 1023 && adv < 1033) got[9-(adv-1023)] = chip;
        end
        chip_en = 1'b0;
        check("epoch_next_chips", got, 10'b1100100000);
        check("epoch_spacing", second_ep - first_ep, 4092);
        check("epoch_pulse_count", ep_count, 2);

        // Slew of 5 chips, no chip_en.
        rst = 1'b1; tick; rst = 1'b0;
        slew_chips = 10'd5; slew_req = 1'b1; tick; slew_req = 1'b0;
        busy_clks = 0;
        while (slew_busy && busy_clks < 50) begin busy_clks++; tick; end
        check("slew5_busy_clks", busy_clks, 5);
        check("slew5_cnt", chip_cnt, 5);
        check("slew5_chip", chip, 0);

        // Slew of 5 chips with two chip_en pulses absorbed.
        rst = 1'b1; tick; rst = 1'b0;
        slew_req = 1'b1; tick; slew_req = 1'b0;
        busy_clks = 0;
        while (slew_busy && busy_clks < 50) begin
            busy_clks++;
            chip_en = (busy_clks == 2 || busy_clks == 4);
            tick;
        end
        chip_en = 1'b0;
        check("slew5p2_busy_clks", busy_clks, 7);
        check("slew5p2_cnt", chip_cnt, 7);

        // rst mid-slew with remaining=3.
        rst = 1'b1; tick; rst = 1'b0;
        slew_req = 1'b1; tick; slew_req = 1'b0;
        tick; tick;
        rst = 1'b1; tick; rst = 1'b0;
        check("rst_slew_busy", slew_busy, 0);
        check("rst_slew_cnt", chip_cnt, 0);
        check("rst_slew_chip", chip, 1);
        tick;
        check("rst_slew_hold_cnt", chip_cnt, 0);

        // reload with chip_en at the last chip: no advance, no epoch.
        chip_en = 1'b1;
        for (int i = 0; i < 1022; i++) tick;
        check("pre_reload_cnt", chip_cnt, 1022);
        reload = 1'b1; tick; reload = 1'b0; chip_en = 1'b0;
        check("reload_cnt", chip_cnt, 0);
        check("reload_epoch", epoch, 0);
        check("reload_chip", chip, 1);
        tick;
        check("reload_epoch_after", epoch, 0);

        // reload cancels a slew.
        slew_chips = 10'd10; slew_req = 1'b1; tick; slew_req = 1'b0;
        tick;
        reload = 1'b1; tick; reload = 1'b0;
        check("reload_slew_busy", slew_busy, 0);
        check("reload_slew_cnt", chip_cnt, 0);

        // CODE_LEN=511 build.
        rst = 1'b1; tick; rst = 1'b0;
        chip_en = 1'b1; ep_at = -1; ep_count = 0; first10 = '0; got = '0; cnt_bad = 0;
        for (int a = 0; a <= 520; a++) begin
            if (a < 10) first10[9-a] = chip_b;
            if (a >= 511) got[9-(a-511)] = chip_b;
            tick;
            if (epoch_b) begin
                ep_count++;
                ep_at = a + 1;
                if (cnt_b != 10'd0) cnt_bad++;
            end
        end
        chip_en = 1'b0;
        check("len511_epoch_at", ep_at, 511);
        check("len511_epoch_count", ep_count, 1);
        check("len511_epoch_cnt_errs", cnt_bad, 0);
        check("len511_first_chips", first10, 10'b1100100000);
        check("len511_repeat_chips", got, first10);

        // Randomised run against the phase model.
        g1_init = 10'($urandom_range(1, 1023));
        g2_init = 10'($urandom_range(1, 1023));
        build_tables(g1_init, g2_init);
        ph = 0; rem = 0; busy_m = 0; ep_m = 0; late_m = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst        = (cyc == 0) || ($urandom_range(0, 499) == 0);
            reload     = ($urandom_range(0, 99) == 0);
            chip_en    = 1'($urandom_range(0, 1));
            slew_req   = ($urandom_range(0, 29) == 0);
            slew_chips = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 400));
            if ($urandom_range(0, 199) == 0) begin
                t0 = 4'($urandom_range(0, 15));
                t1 = 4'($urandom_range(0, 15));
            end
            if (rst || reload) begin
                ph = 0; busy_m = 0; rem = 0; ep_m = 0; late_m = 0;
            end else begin
                logic adv_m;
                adv_m = busy_m || chip_en;
                ep_m = 0;
                if (busy_m) begin
                    if (!chip_en) begin
                        rem--;
                        if (rem == 0) busy_m = 0;
                    end
                end else if (slew_req && slew_chips != 0) begin
                    busy_m = 1; rem = slew_chips;
                end
                if (adv_m) begin
                    late_m = exp_chip(ph);
                    ph = (ph + 1) % 1023;
                    ep_m = (ph == 0);
                end
            end
            tick;
            act = {chip, epoch, slew_busy, chip_cnt};
            exp = {exp_chip(ph), ep_m, busy_m, 10'(ph)};
`ifdef GOLD_ELP_EN
            act = {act[12:0], chip_early, chip_late};
            exp = {exp[12:0], exp_chip((ph + 1) % 1023), late_m};
`endif
            check($sformatf("rand_cyc%0d", cyc), act, exp);
        end
        rst = 1'b0; reload = 1'b0; chip_en = 1'b0; slew_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gold_code_gen.md
Name: gold_code_gen

Overview:
- Parametrised Gold-code PRN generator; successor to the fixed 10-stage C/A generator.
- Two Fibonacci LFSRs (G1, G2) with parameterised polynomials and length.
- Output chip = G1 out XOR two runtime-selected G2 phase taps.
- Adds chip-enable pacing from the carrier/code NCO, a code-length counter with epoch pulse, synchronous reload, and a code-phase slew state machine for the acquisition/tracking loops.

Parameters:
LFSR_W, 10, LFSR stage count
CODE_LEN, 1023, chips per code period; counter wraps and both LFSRs reload after CODE_LEN advances
G1_POLY, 10'h204, G1 feedback mask; bit i set = stage i+1 tapped (GPS: stages 3,10)
G2_POLY, 10'h3A6, G2 feedback mask (GPS: stages 2,3,6,8,9,10)
TAP_W, 4, width of T0/T1 stage selectors
CNT_W, 10, width of chip_cnt and slew_chips (>= clog2(CODE_LEN))

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
g1_init  in  LFSR_W  G1 load value (bit i = stage i+1)
g2_init  in  LFSR_W  G2 load value
T0  in  TAP_W  first G2 output stage, 1-based
T1  in  TAP_W  second G2 output stage, 1-based
chip_en  in  1  advance-one-chip strobe
reload  in  1  restart code at chip 0
slew_req  in  1  start slew; sampled only when slew_busy=0
slew_chips  in  CNT_W  extra chips to advance
chip  out  1  current code chip
chip_cnt  out  CNT_W  index of current chip, 0..CODE_LEN-1
epoch  out  1  one-clk pulse at code wrap
slew_busy  out  1  high while in SLEW

Behaviour:
- The clock port is clk. The reset port is rst. Reset is synchronous and active-high.
- Stage k = reg bit k-1.
- Advance operation:
  - s <= {s[W-2:0], ^(s & POLY)} for both G1 and G2.
  - chip_cnt increments.
  - If chip_cnt == CODE_LEN-1 before the advance: reload G1/G2 from g1_init/g2_init, set chip_cnt to 0, and register epoch=1 for the next clock only.
- chip is combinational: G1 stage LFSR_W XOR G2 stage T0 XOR G2 stage T1. T0/T1 outside 1..LFSR_W read as 0.
- rst:
  - G1=g1_init, G2=g2_init.
  - chip_cnt=0, epoch=0, slew_busy=0, state=IDLE.
  - chip reflects init state immediately (PRN1 all-ones: chip=1).
- Priority: rst > reload > advance.
  - reload: same as rst except it is not a reset. It cancels any slew (state to IDLE) and no epoch is generated.
- FSM IDLE:
  - Advance only on chip_en.
  - slew_req with slew_chips>0: load remaining=slew_chips, go to SLEW, slew_busy=1 from the next clock.
  - slew_chips=0: no-op.
- FSM SLEW:
  - Advance every clock.
  - If chip_en=0 that clock, remaining decrements. If chip_en=1, the advance serves chip_en and remaining is unchanged.
  - When remaining reaches 0, return to IDLE; slew_busy falls in the same edge.
  - Net phase shift = exactly slew_chips.
  - slew_req is ignored in SLEW.
  - Epoch wrap during slew behaves as a normal wrap.
- Latency: chip and chip_cnt update on the clock edge after chip_en sampled high.
- g1_init/g2_init are sampled only at rst, reload and wrap.

Optional Feature:
- Macro GOLD_ELP_EN. Defined: adds outputs chip_early (1) and chip_late (1).
  - chip_early is combinational: the chip the next advance would produce, including wrap-to-init at CODE_LEN-1.
  - chip_late is registered: it takes the current chip value on each advance, and is 0 after rst/reload.
  - Gives E/P/L with one-chip spacing for the DLL.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- PRN1 (T0=2, T1=6, inits all ones), rst pulse, chip_en every clk -> first 10 chips 1100100000; chip_cnt 0..9.
- PRN2 (T0=3, T1=7) same setup -> first 10 chips 1110010000.
- PRN1, chip_en every 4th clk for 1023+10 chips:
  - epoch high exactly 1 clk after the 1023rd advance;
  - chip_cnt=0 at the epoch;
  - next 10 chips 1100100000;
  - epoch spacing 4092 clks.
- Slew, chip_en=0, slew_chips=5 from chip 0 -> slew_busy high 5 clks, then chip_cnt=5, chip=0. Repeat with 2 chip_en pulses during slew -> busy 7 clks, chip_cnt=7.
- CODE_LEN=511 build -> epoch after 511 advances; G1/G2 back to init; chips 0..9 repeat.
- rst asserted mid-slew (remaining=3) -> next clk slew_busy=0, chip_cnt=0, chip=1. reload with chip_en same clk -> chip_cnt=0, no advance, no epoch.
